// File: rtl/flight_cmd_pkg.sv
// Shared opcode constants and scheduler state type for the flight command path.
package flight_cmd_pkg;

  localparam logic [7:0] SET_PITCH = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

  localparam logic [7:0] RESP_ACK  = 8'hA5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    WAIT_RESP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO holding {opcode, data} entries; flush beats push and pop.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic           do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/cmd_sched.sv
// Command scheduler: queues remote commands, issues them one at a time to
// cmd_cfg, forwards responses, and injects EMER_LAND on link loss.
module cmd_sched
  import flight_cmd_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter bit FAST_SIM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vld,
  input  logic [7:0]  in_cmd,
  input  logic [15:0] in_data,
  output logic        in_full,
  output logic        ovf,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        resp_vld,
  output logic [7:0]  resp_out,
  input  logic        motors_off,
  output logic        failsafe
);

  localparam int WD_W = FAST_SIM ? 9 : 26;

  sched_state_t state_q, state_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        resp_vld_q, resp_vld_d;
  logic [7:0]  resp_out_q, resp_out_d;
  logic        ovf_q, ovf_d;
  logic        failsafe_q, failsafe_d;
  logic        fs_pend_q, fs_pend_d;
  logic        int_cmd_q, int_cmd_d;
  logic        resp_seen_q, resp_seen_d;
  logic [7:0]  resp_hold_q, resp_hold_d;
  logic [WD_W-1:0] wdog_q, wdog_d;

  logic        fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [23:0] fifo_dout;
  logic        inject, push_ok;

  assign fifo_push = in_vld && !fifo_full;
  assign in_full   = fifo_full;
  assign ovf       = ovf_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign cmd       = cmd_q;
  assign data      = data_q;
  assign resp_vld  = resp_vld_q;
  assign resp_out  = resp_out_q;
  assign failsafe  = failsafe_q;

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(24)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   ({in_cmd, in_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue FSM: failsafe injection wins at IDLE, then FIFO head; handshake in BUSY/WAIT_RESP.
  always_comb begin
    state_d     = state_q;
    cmd_rdy_d   = cmd_rdy_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    resp_vld_d  = 1'b0;
    resp_out_d  = resp_out_q;
    int_cmd_d   = int_cmd_q;
    resp_seen_d = resp_seen_q;
    resp_hold_d = resp_hold_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    inject      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fs_pend_q) begin
          inject      = 1'b1;
          fifo_flush  = 1'b1;
          cmd_d       = EMER_LAND;
          data_d      = '0;
          cmd_rdy_d   = 1'b1;
          int_cmd_d   = 1'b1;
          resp_seen_d = 1'b0;
          state_d     = BUSY;
        end else if (!fifo_empty) begin
          fifo_pop        = 1'b1;
          {cmd_d, data_d} = fifo_dout;
          cmd_rdy_d       = 1'b1;
          int_cmd_d       = 1'b0;
          resp_seen_d     = 1'b0;
          state_d         = BUSY;
        end
      end
      BUSY: begin
        if (clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
          if (send_resp || resp_seen_q) begin
            if (!int_cmd_q) begin
              resp_vld_d = 1'b1;
              resp_out_d = send_resp ? resp : resp_hold_q;
            end
            resp_seen_d = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = WAIT_RESP;
          end
        end else if (send_resp) begin
          resp_seen_d = 1'b1;
          resp_hold_d = resp;
        end
      end
      WAIT_RESP: begin
        if (send_resp) begin
          if (!int_cmd_q) begin
            resp_vld_d = 1'b1;
            resp_out_d = resp;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Link watchdog, failsafe flag and overflow tracking.
  always_comb begin
    push_ok    = fifo_push && !inject;
    wdog_d     = wdog_q;
    fs_pend_d  = fs_pend_q;
    failsafe_d = failsafe_q;
    ovf_d      = ovf_q;
    if (push_ok || motors_off) begin
      wdog_d = '0;
    end else if (!(&wdog_q)) begin
      wdog_d = wdog_q + 1'b1;
    end
    if (inject) begin
      fs_pend_d = 1'b0;
    end else if ((&wdog_q) && !failsafe_q) begin
      fs_pend_d = 1'b1;
    end
    if (inject) begin
      failsafe_d = 1'b1;
    end else if (push_ok) begin
      failsafe_d = 1'b0;
    end
    if (in_vld && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_rdy_q   <= 1'b0;
      cmd_q       <= '0;
      data_q      <= '0;
      resp_vld_q  <= 1'b0;
      resp_out_q  <= '0;
      ovf_q       <= 1'b0;
      failsafe_q  <= 1'b0;
      fs_pend_q   <= 1'b0;
      int_cmd_q   <= 1'b0;
      resp_seen_q <= 1'b0;
      resp_hold_q <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_rdy_q   <= cmd_rdy_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      resp_vld_q  <= resp_vld_d;
      resp_out_q  <= resp_out_d;
      ovf_q       <= ovf_d;
      failsafe_q  <= failsafe_d;
      fs_pend_q   <= fs_pend_d;
      int_cmd_q   <= int_cmd_d;
      resp_seen_q <= resp_seen_d;
      resp_hold_q <= resp_hold_d;
      wdog_q      <= wdog_d;
    end
  end

endmodule
